mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, cycles spent in REQ plus WAIT before an access is aborted with an error; legal range 1..1023.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 m0_req / m1_req  in  1  access request (port 0 instruction fetch, port 1 load/store); held with its fields stable until the port's gnt.
REQ-005 m0_addr / m1_addr  in  32  byte address.
REQ-006 m0_we / m1_we  in  1  1 = store, 0 = load.
REQ-007 m0_size / m1_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-008 m0_wdata / m1_wdata  in  32  store data, right-aligned.
REQ-009 m0_gnt / m1_gnt  out  1  one-cycle pulse: request latched.
REQ-010 m0_done / m1_done  out  1  one-cycle pulse: access finished.
REQ-011 m0_err / m1_err  out  1  qualifies done: access failed.
REQ-012 m0_rdata / m1_rdata  out  32  load data, valid with done.
REQ-013 mem_req  out  1  access strobe to the single-ported data memory.
REQ-014 mem_addr, mem_we, mem_size, mem_wdata  out  32/1/2/32  latched request fields.
REQ-015 mem_ready  in  1  memory accepts mem_req this cycle.
REQ-016 mem_rvalid / mem_rdata  in  1/32  read response and its data.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered or decoded from state only; no input-to-output combinational path.
REQ-018 IDLE with any req asserted: select a winner, latch its fields and owner id, pulse that port's gnt the next cycle, and go to REQ.
REQ-019 Arbitration is round-robin on a last_owner bit: if both ports request, the port that was not last_owner wins. A single requester always wins.
REQ-020 At latch time, an illegal size (3) or a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) goes to RESP with err=1 and rdata=0. No memory access is issued.
REQ-021 In REQ, mem_req=1. On mem_ready: a store goes to RESP with err=0; a load goes to WAIT.
REQ-022 In WAIT, on mem_rvalid, capture mem_rdata into the owner's rdata and go to RESP.
REQ-023 In RESP, pulse the owner's done and err for exactly one cycle, update last_owner to the owner, and return to IDLE.
REQ-024 Latency with ready memory, from request sampled at edge N: gnt in cycle N+1. A store's done is in cycle N+2. A load with rvalid in cycle K has done in cycle K+1.
REQ-025 A new request may be sampled in the cycle done is high, because the FSM is back in IDLE.
REQ-026 Timeout: a 10-bit counter clears on entering REQ and increments each cycle in REQ or WAIT. When it equals TIMEOUT: go to RESP with err=1 and rdata=0, and drop mem_req.
REQ-027 mem_rvalid in IDLE, REQ, or RESP, or arriving after a timeout, is ignored.
REQ-028 The non-owner port sees gnt=0 and done=0 throughout the owner's access. Its rdata holds its last value.
REQ-029 mem_addr, mem_we, mem_size, and mem_wdata stay constant from REQ entry until return to IDLE.

Reset
REQ-030 With rst=0, immediately and regardless of clk: state=IDLE, mem_req=0, all gnt/done/err=0, all rdata=0, mem_addr/mem_wdata=0, mem_we=0, mem_size=0, counter=0, last_owner=1 (port 0 wins the first tie).
REQ-031 Reset asserted mid-access abandons that access without a done pulse. Any later mem_rvalid is ignored.

Verification
REQ-032 Both ports request after reset: m0 lw 0x100 and m1 sw 0x200 with wdata 0xA5A5A5A5, memory always ready. Required: m0_gnt first; load done with the memory's data; then m1_gnt; store done, err=0.
REQ-033 Both ports hold requests continuously for 4 accesses. Required: grants alternate 0,1,0,1, and gnt never pulses on both ports in one cycle.
REQ-034 m1 lh at 0x103. Required: m1_done=1 and m1_err=1 in cycle N+2, m1_rdata=0, mem_req never asserted.
REQ-035 TIMEOUT=4, load with mem_ready=1 and mem_rvalid never asserted. Required: done with err=1 and rdata=0 exactly 4 cycles after WAIT entry; a later rvalid is ignored.
REQ-036 rst pulled low while in WAIT. Required: mem_req=0 and state IDLE without a clock edge. After release, a late rvalid produces no done, and the next tie is won by port 0.
REQ-037 Load with mem_ready delayed 3 cycles and rvalid 2 cycles later. Required: mem_addr stable throughout, done one cycle after rvalid, and the non-owner port's outputs unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Two requester ports (m0 fetch, m1 load/store) and the single-ported memory side of mem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and memory responses.
interface mem_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_we;
  logic [1:0]  m0_size;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_done;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_we;
  logic [1:0]  m1_size;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_done;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_size, m0_wdata,
    input  m1_req, m1_addr, m1_we, m1_size, m1_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output m0_gnt, m0_done, m0_err, m0_rdata,
    output m1_gnt, m1_done, m1_err, m1_rdata,
    output mem_req, mem_addr, mem_we, mem_size, mem_wdata
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_size, m0_wdata,
    output m1_req, m1_addr, m1_we, m1_size, m1_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  m0_gnt, m0_done, m0_err, m0_rdata,
    input  m1_gnt, m1_done, m1_err, m1_rdata,
    input  mem_req, mem_addr, mem_we, mem_size, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of two requesters onto one data memory; gnt one cycle after the request is
// sampled, done one cycle after mem_ready (store) or mem_rvalid (load); mem_req held until mem_ready.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        bad_q, bad_d;
  logic        err_q, err_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;

  logic        any_req, last_eff, win, sel_we, sel_bad, timeout;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;
  logic        rd_wr;
  logic [31:0] rd_val;

  // RESP arbitrates like IDLE, treating the finishing owner as last_owner so back-to-back ties alternate.
  assign any_req   = bus.m0_req | bus.m1_req;
  assign last_eff  = (state_q == RESP) ? owner_q : last_owner_q;
  assign win       = (bus.m0_req & bus.m1_req) ? ~last_eff : bus.m1_req;
  assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
  assign sel_we    = win ? bus.m1_we    : bus.m0_we;
  assign sel_size  = win ? bus.m1_size  : bus.m0_size;
  assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
  assign sel_bad   = (sel_size == 2'd3) ||
                     ((sel_size == 2'd1) && sel_addr[0]) ||
                     ((sel_size == 2'd2) && (sel_addr[1:0] != 2'd0));
  assign timeout   = (cnt_q == TMO);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    bad_d        = bad_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    gnt_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    size_d       = size_q;
    rd_wr        = 1'b0;
    rd_val       = 32'd0;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) last_owner_d = owner_q;
        state_d = IDLE;
        if (any_req) begin
          owner_d    = win;
          gnt_d[win] = 1'b1;
          addr_d     = sel_addr;
          we_d       = sel_we;
          size_d     = sel_size;
          wdata_d    = sel_wdata;
          bad_d      = sel_bad;
          err_d      = 1'b0;
          cnt_d      = 10'd0;
          state_d    = REQ;
        end
      end
      // A rejected request still spends one cycle in REQ (without mem_req) so done follows gnt.
      REQ: begin
        cnt_d = cnt_q + 10'd1;
        if (timeout || bad_q) begin
          state_d = RESP;
          err_d   = 1'b1;
          rd_wr   = 1'b1;
        end else if (bus.mem_ready) begin
          state_d = we_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 10'd1;
        if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rd_wr   = 1'b1;
        end else if (bus.mem_rvalid) begin
          state_d = RESP;
          rd_wr   = 1'b1;
          rd_val  = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_wr) begin
      if (owner_q) rdata1_d = rd_val;
      else         rdata0_d = rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      bad_q        <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 10'd0;
      gnt_q        <= 2'b00;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      bad_q        <= bad_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      size_q       <= size_d;
    end
  end

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_done   = (state_q == RESP) && !owner_q;
  assign bus.m1_done   = (state_q == RESP) && owner_q;
  assign bus.m0_err    = (state_q == RESP) && !owner_q && err_q;
  assign bus.m1_err    = (state_q == RESP) && owner_q && err_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_req   = (state_q == REQ) && !bad_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table with an always-ready memory, then hand sequences for
// async reset mid-access, slow memory, and timeout (second instance with TIMEOUT=4).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter_if tbus ();

  mem_arbiter u_dut (.clk(clk), .rst(rst_n), .bus(bus));
  mem_arbiter #(.TIMEOUT(4)) u_dut_to (.clk(clk), .rst(rst_n), .bus(tbus));

  typedef struct packed {
    logic [1:0]  gnt;   // {m1, m0}
    logic [1:0]  done;
    logic [1:0]  err;
    logic        mreq;
    logic [31:0] maddr;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  req;   // {m1, m0}
    logic [31:0] a0;
    logic [2:0]  op0;   // {we, size}
    logic [31:0] a1;
    logic [2:0]  op1;
    logic        rv;
    logic [31:0] rdat;
    exp_t        e;
  } vec_t;

  localparam logic [2:0] LW = 3'b010, SW = 3'b110, LH = 3'b001, BAD = 3'b011;
  localparam logic [31:0] D = 32'hDEADBEEF, C = 32'h12345678;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl[$];

  function automatic vec_t mk(string n, logic [1:0] req, logic [31:0] a0, logic [2:0] op0,
                              logic [31:0] a1, logic [2:0] op1, logic rv, logic [31:0] rdat,
                              logic [1:0] gnt, logic [1:0] done, logic [1:0] err, logic mreq,
                              logic [31:0] maddr, logic [31:0] rd0, logic [31:0] rd1);
    vec_t v;
    v.name = n; v.req = req; v.a0 = a0; v.op0 = op0; v.a1 = a1; v.op1 = op1;
    v.rv = rv; v.rdat = rdat;
    v.e = '{gnt: gnt, done: done, err: err, mreq: mreq, maddr: maddr, rd0: rd0, rd1: rd1};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    exp_t act;

    bus.m0_req = 0; bus.m0_addr = 0; bus.m0_we = 0; bus.m0_size = 0; bus.m0_wdata = 32'h11112222;
    bus.m1_req = 0; bus.m1_addr = 0; bus.m1_we = 0; bus.m1_size = 0; bus.m1_wdata = 32'hA5A5A5A5;
    bus.mem_ready = 1; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    tbus.m0_req = 0; tbus.m0_addr = 0; tbus.m0_we = 0; tbus.m0_size = 0; tbus.m0_wdata = 0;
    tbus.m1_req = 0; tbus.m1_addr = 0; tbus.m1_we = 0; tbus.m1_size = 0; tbus.m1_wdata = 0;
    tbus.mem_ready = 0; tbus.mem_rvalid = 0; tbus.mem_rdata = 0;

    //            name         req   a0     op0  a1     op1 rv rdat          gnt   done  err   mr maddr  rd0 rd1
    tbl.push_back(mk("tie_idle",   2'b11, 32'h100, LW, 32'h200, SW, 0, 0,            2'b00, 2'b00, 2'b00, 0, 32'h0,   0, 0));
    tbl.push_back(mk("m0_gnt",     2'b10, 32'h100, LW, 32'h200, SW, 0, 0,            2'b01, 2'b00, 2'b00, 1, 32'h100, 0, 0));
    tbl.push_back(mk("m0_wait",    2'b10, 32'h100, LW, 32'h200, SW, 1, D,            2'b00, 2'b00, 2'b00, 0, 32'h100, 0, 0));
    tbl.push_back(mk("m0_done",    2'b10, 32'h100, LW, 32'h200, SW, 0, 0,            2'b00, 2'b01, 2'b00, 0, 32'h100, D, 0));
    tbl.push_back(mk("m1_gnt",     2'b10, 32'h100, LW, 32'h200, SW, 0, 0,            2'b10, 2'b00, 2'b00, 1, 32'h200, D, 0));
    tbl.push_back(mk("m1_done",    2'b00, 32'h100, LW, 32'h200, SW, 0, 0,            2'b00, 2'b10, 2'b00, 0, 32'h200, D, 0));
    tbl.push_back(mk("idle1",      2'b00, 32'h100, LW, 32'h200, SW, 0, 0,            2'b00, 2'b00, 2'b00, 0, 32'h200, D, 0));
    tbl.push_back(mk("rr_idle",    2'b11, 32'h300, SW, 32'h400, SW, 0, 0,            2'b00, 2'b00, 2'b00, 0, 32'h200, D, 0));
    tbl.push_back(mk("rr_g0a",     2'b11, 32'h300, SW, 32'h400, SW, 0, 0,            2'b01, 2'b00, 2'b00, 1, 32'h300, D, 0));
    tbl.push_back(mk("rr_d0a",     2'b11, 32'h300, SW, 32'h400, SW, 0, 0,            2'b00, 2'b01, 2'b00, 0, 32'h300, D, 0));
    tbl.push_back(mk("rr_g1a",     2'b11, 32'h300, SW, 32'h400, SW, 0, 0,            2'b10, 2'b00, 2'b00, 1, 32'h400, D, 0));
    tbl.push_back(mk("rr_d1a",     2'b11, 32'h300, SW, 32'h400, SW, 0, 0,            2'b00, 2'b10, 2'b00, 0, 32'h400, D, 0));
    tbl.push_back(mk("rr_g0b",     2'b11, 32'h300, SW, 32'h400, SW, 0, 0,            2'b01, 2'b00, 2'b00, 1, 32'h300, D, 0));
    tbl.push_back(mk("rr_d0b",     2'b11, 32'h300, SW, 32'h400, SW, 0, 0,            2'b00, 2'b01, 2'b00, 0, 32'h300, D, 0));
    tbl.push_back(mk("rr_g1b",     2'b00, 32'h300, SW, 32'h400, SW, 0, 0,            2'b10, 2'b00, 2'b00, 1, 32'h400, D, 0));
    tbl.push_back(mk("rr_d1b",     2'b00, 32'h300, SW, 32'h400, SW, 0, 0,            2'b00, 2'b10, 2'b00, 0, 32'h400, D, 0));
    tbl.push_back(mk("m1lw_idle",  2'b10, 32'h0,   LW, 32'h204, LW, 0, 0,            2'b00, 2'b00, 2'b00, 0, 32'h400, D, 0));
    tbl.push_back(mk("m1lw_gnt",   2'b00, 32'h0,   LW, 32'h204, LW, 0, 0,            2'b10, 2'b00, 2'b00, 1, 32'h204, D, 0));
    tbl.push_back(mk("m1lw_wait",  2'b00, 32'h0,   LW, 32'h204, LW, 1, C,            2'b00, 2'b00, 2'b00, 0, 32'h204, D, 0));
    tbl.push_back(mk("m1lw_done",  2'b00, 32'h0,   LW, 32'h204, LW, 0, 0,            2'b00, 2'b10, 2'b00, 0, 32'h204, D, C));
    tbl.push_back(mk("lh_idle",    2'b10, 32'h0,   LW, 32'h103, LH, 0, 0,            2'b00, 2'b00, 2'b00, 0, 32'h204, D, C));
    tbl.push_back(mk("lh_gnt",     2'b00, 32'h0,   LW, 32'h103, LH, 0, 0,            2'b10, 2'b00, 2'b00, 0, 32'h103, D, C));
    tbl.push_back(mk("lh_done",    2'b00, 32'h0,   LW, 32'h103, LH, 0, 0,            2'b00, 2'b10, 2'b10, 0, 32'h103, D, 0));
    tbl.push_back(mk("bad_idle",   2'b01, 32'h0,  BAD, 32'h103, LH, 0, 0,            2'b00, 2'b00, 2'b00, 0, 32'h103, D, 0));
    tbl.push_back(mk("bad_gnt",    2'b00, 32'h0,  BAD, 32'h103, LH, 0, 0,            2'b01, 2'b00, 2'b00, 0, 32'h0,   D, 0));
    tbl.push_back(mk("bad_done",   2'b00, 32'h0,  BAD, 32'h103, LH, 0, 0,            2'b00, 2'b01, 2'b01, 0, 32'h0,   0, 0));
    tbl.push_back(mk("stray_rv",   2'b00, 32'h0,   LW, 32'h0,   LW, 1, 32'hFFFFFFFF, 2'b00, 2'b00, 2'b00, 0, 32'h0,   0, 0));
    tbl.push_back(mk("stray_chk",  2'b00, 32'h0,   LW, 32'h0,   LW, 0, 0,            2'b00, 2'b00, 2'b00, 0, 32'h0,   0, 0));

    // Reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset_vals", 128'({bus.m1_gnt, bus.m0_gnt, bus.m1_done, bus.m0_done, bus.m1_err, bus.m0_err,
                            bus.mem_req, bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata,
                            bus.m0_rdata}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      bus.m0_req = tbl[i].req[0]; bus.m0_addr = tbl[i].a0;
      bus.m0_we = tbl[i].op0[2];  bus.m0_size = tbl[i].op0[1:0];
      bus.m1_req = tbl[i].req[1]; bus.m1_addr = tbl[i].a1;
      bus.m1_we = tbl[i].op1[2];  bus.m1_size = tbl[i].op1[1:0];
      bus.mem_ready = 1'b1; bus.mem_rvalid = tbl[i].rv; bus.mem_rdata = tbl[i].rdat;
      #1;
      act = '{gnt: {bus.m1_gnt, bus.m0_gnt}, done: {bus.m1_done, bus.m0_done},
              err: {bus.m1_err, bus.m0_err}, mreq: bus.mem_req, maddr: bus.mem_addr,
              rd0: bus.m0_rdata, rd1: bus.m1_rdata};
      chk(tbl[i].name, {25'd0, act}, {25'd0, tbl[i].e});
      step();
    end
    bus.mem_rvalid = 0; bus.mem_rdata = 0;

    // Async reset while a load sits in WAIT
    bus.m0_req = 1; bus.m0_addr = 32'h500; bus.m0_we = 0; bus.m0_size = 2; bus.m1_req = 0;
    step();
    bus.m0_req = 0;
    step();
    chk("wait_before_rst", 128'({bus.mem_req, bus.mem_addr}), 128'({1'b0, 32'h500}));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 128'({bus.mem_req, bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done,
                           bus.m0_err, bus.m1_err, bus.mem_addr, bus.mem_wdata, bus.m0_rdata}), 128'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h99;
    step();
    bus.mem_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("late_rv_%0d", k), 128'({bus.m0_done, bus.m1_done, bus.m0_rdata}), 128'd0);
      step();
    end

    // First tie after reset goes to port 0
    bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_we = 1; bus.m0_size = 2;
    bus.m1_req = 1; bus.m1_addr = 32'h20; bus.m1_we = 0; bus.m1_size = 2;
    step();
    chk("tie_after_rst", 128'({bus.m1_gnt, bus.m0_gnt, bus.mem_we, bus.mem_size, bus.mem_wdata, bus.mem_addr}),
        128'({2'b01, 1'b1, 2'd2, 32'h11112222, 32'h10}));
    bus.m0_req = 0;
    step();
    chk("st_done", 128'({bus.m1_done, bus.m0_done, bus.m0_err}), 128'({2'b01, 1'b0}));
    step();
    chk("m1_gnt2", 128'({bus.m1_gnt, bus.m0_gnt, bus.mem_req, bus.mem_addr}), 128'({2'b10, 1'b1, 32'h20}));
    bus.m1_req = 0;
    step();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h0BADCAFE;
    step();
    bus.mem_rvalid = 0;
    chk("m1_ld_done", 128'({bus.m1_done, bus.m1_err, bus.m1_rdata}), 128'({1'b1, 1'b0, 32'h0BADCAFE}));
    step();

    // Slow memory: ready after 3 stalled cycles, rvalid 2 cycles later; m1 waits its turn
    bus.m0_req = 1; bus.m0_addr = 32'h600; bus.m0_we = 0; bus.m0_size = 2;
    bus.m1_req = 1; bus.m1_addr = 32'h700; bus.m1_we = 0; bus.m1_size = 2;
    bus.mem_ready = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      bus.m0_req = 0;
      bus.mem_ready = (i == 3);
      bus.mem_rvalid = (i == 5);
      bus.mem_rdata = 32'h5566AA77;
      chk($sformatf("slow_ld_%0d", i),
          128'({bus.m0_gnt, bus.m0_done, bus.m0_err, bus.m1_gnt, bus.m1_done, bus.m1_err,
                bus.mem_req, bus.mem_addr, bus.m0_rdata, bus.m1_rdata}),
          128'({(i == 0), (i == 6), 1'b0, 1'b0, 1'b0, 1'b0, (i <= 3), 32'h600,
                ((i == 6) ? 32'h5566AA77 : 32'h0), 32'h0BADCAFE}));
    end
    bus.m1_req = 0; bus.mem_ready = 0; bus.mem_rvalid = 0;

    // TIMEOUT=4 instance: one good load, then a load whose rvalid never comes
    tbus.m0_req = 1; tbus.m0_addr = 32'h40; tbus.m0_size = 2; tbus.mem_ready = 1;
    step();
    tbus.m0_req = 0;
    step();
    tbus.mem_rvalid = 1; tbus.mem_rdata = 32'hCAFEF00D;
    step();
    tbus.mem_rvalid = 0;
    chk("to_ok", 128'({tbus.m0_done, tbus.m0_err, tbus.m0_rdata}), 128'({1'b1, 1'b0, 32'hCAFEF00D}));
    step();
    tbus.m0_req = 1; tbus.m0_addr = 32'h44;
    step();
    chk("to_req", 128'({tbus.m0_gnt, tbus.mem_req}), 128'({1'b1, 1'b1}));
    tbus.m0_req = 0;
    step();
    for (int k = 0; k <= 4; k++) begin
      chk($sformatf("to_wait_%0d", k), 128'({tbus.mem_req, tbus.m0_done, tbus.m0_err, tbus.m0_rdata}),
          128'({1'b0, (k == 4), (k == 4), ((k == 4) ? 32'h0 : 32'hCAFEF00D)}));
      if (k < 4) step();
    end
    step();
    tbus.mem_rvalid = 1; tbus.mem_rdata = 32'h77;
    step();
    tbus.mem_rvalid = 0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("to_late_rv_%0d", k), 128'({tbus.m0_done, tbus.m0_rdata}), 128'd0);
      step();
    end

    // Stalled memory: mem_req drops when the timeout fires in REQ
    tbus.mem_ready = 0; tbus.m0_req = 1; tbus.m0_addr = 32'h48;
    step();
    tbus.m0_req = 0;
    for (int i = 0; i <= 5; i++) begin
      chk($sformatf("stall_to_%0d", i), 128'({tbus.mem_req, tbus.m0_done, tbus.m0_err}),
          128'({(i < 5), (i == 5), (i == 5)}));
      if (i < 5) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
